// File: rtl/slice_borrow_subtractor_if.sv
// Handshake bundle for slice_borrow_subtractor.
// The optional ovf signal exists only when SUB_OVF_EN is defined.
// master: operand producer / result consumer side. slave: the subtractor.
interface slice_borrow_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
`endif
endinterface

// File: rtl/slice_borrow_subtractor.sv
// Multi-cycle unsigned subtractor: {bout,diff} = a - b - bin, resolving SLICE
// bits per clock from the LSB slice upward with the borrow held in a register.
// Optional feature macro: SUB_OVF_EN adds a registered signed-overflow flag.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | in_ready=1, waiting for operands
//  S_CALC | one slice per cycle, borrow rippled through br_q
//  S_DONE | out_valid=1, result held until out_ready
module slice_borrow_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    slice_borrow_subtractor_if.slave bus
);
    localparam int NS    = WIDTH / SLICE;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
`ifdef SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               accept;
    logic               last_slice;
    int                 slice_off;
    logic [SLICE-1:0]   a_sl;
    logic [SLICE-1:0]   b_sl;
    logic [SLICE-1:0]   d_sl;
    logic               br_out;

    assign accept     = (state_q == S_IDLE) && bus.in_valid;
    assign last_slice = (idx_q == IDX_W'(NS - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, NS slice cycles, hold until consumer takes result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid)  state_d = S_CALC;
            S_CALC: if (last_slice)    state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
    end

    // Ripple the borrow across the bits of the current slice.
    always_comb begin
        logic br;
        slice_off = int'(idx_q) * SLICE;
        a_sl      = a_q[slice_off +: SLICE];
        b_sl      = b_q[slice_off +: SLICE];
        d_sl      = '0;
        br        = br_q;
        for (int i = 0; i < SLICE; i++) begin
            d_sl[i] = a_sl[i] ^ b_sl[i] ^ br;
            br      = (~a_sl[i] & b_sl[i]) | (~(a_sl[i] ^ b_sl[i]) & br);
        end
        br_out = br;
    end

    // Datapath next values: latch on accept, write one diff slice per CALC cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        br_d   = br_q;
        idx_d  = idx_q;
        diff_d = diff_q;
        bout_d = bout_q;
`ifdef SUB_OVF_EN
        ovf_d  = ovf_q;
`endif
        if (accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            br_d  = bus.bin;
            idx_d = '0;
        end else if (state_q == S_CALC) begin
            diff_d[slice_off +: SLICE] = d_sl;
            br_d  = br_out;
            idx_d = idx_q + IDX_W'(1);
            if (last_slice) begin
                bout_d = br_out;
`ifdef SUB_OVF_EN
                // d_sl[SLICE-1] is the MSB of the final difference.
                ovf_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_sl[SLICE-1] ^ a_q[WIDTH-1]);
`endif
            end
        end
    end

    // Datapath registers; results persist after DONE until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            br_q   <= 1'b0;
            idx_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            br_q   <= br_d;
            idx_q  <= idx_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
`ifdef SUB_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
